// File: rtl/dcache_assoc_mem_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg : shared definitions for the set-associative L1 data array.
//   - default geometry (sets, ways, tag and line widths)
//   - dc_line_t  : one cache line {valid, dirty, tag, data}
//   - dc_evict_t : one eviction-buffer entry {idx, tag, data}
//   - age_w()    : width of one LRU age counter for a given associativity
// No ports; imported by the interface, the top and the LRU sub-module.
// ---------------------------------------------------------------------------
package dcache_pkg;

   localparam int DCACHE_SETS   = 32;
   localparam int DCACHE_WAYS   = 2;
   localparam int DCACHE_TAG_W  = 8;
   localparam int DCACHE_DATA_W = 64;
   localparam int DCACHE_IDX_W  = $clog2(DCACHE_SETS);

   typedef struct packed {
      logic                     valid;
      logic                     dirty;
      logic [DCACHE_TAG_W-1:0]  tag;
      logic [DCACHE_DATA_W-1:0] data;
   } dc_line_t;

   typedef struct packed {
      logic [DCACHE_IDX_W-1:0]  idx;
      logic [DCACHE_TAG_W-1:0]  tag;
      logic [DCACHE_DATA_W-1:0] data;
   } dc_evict_t;

   // A direct-mapped build still needs a 1-bit way/age field to keep
   // every vector non-empty.
   function automatic int age_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/dcache_assoc_mem_if.sv
// ---------------------------------------------------------------------------
// dcache_assoc_mem_if : all request/response signals of the data array.
//   LSQ load port  : ld_rd_en/idx/tag -> ld_rd_data, ld_rd_hit
//   LSQ store port : st_wr_en/idx/tag/data -> st_wr_done
//   Fill port      : fill_en/idx/tag/data, fill_ready (back-pressure)
//   Eviction port  : evict_valid/idx/tag/data, evict_ready (valid/ready)
// modport slave  : the data array itself
// modport master : the LSQ / controller side that drives requests
// ---------------------------------------------------------------------------
interface dcache_assoc_mem_if
   import dcache_pkg::*;
#(
   parameter int IDX_W  = DCACHE_IDX_W,
   parameter int TAG_W  = DCACHE_TAG_W,
   parameter int DATA_W = DCACHE_DATA_W
);

   logic              ld_rd_en;
   logic [IDX_W-1:0]  ld_rd_idx;
   logic [TAG_W-1:0]  ld_rd_tag;
   logic [DATA_W-1:0] ld_rd_data;
   logic              ld_rd_hit;

   logic              st_wr_en;
   logic [IDX_W-1:0]  st_wr_idx;
   logic [TAG_W-1:0]  st_wr_tag;
   logic [DATA_W-1:0] st_wr_data;
   logic              st_wr_done;

   logic              fill_en;
   logic [IDX_W-1:0]  fill_idx;
   logic [TAG_W-1:0]  fill_tag;
   logic [DATA_W-1:0] fill_data;
   logic              fill_ready;

   logic              evict_valid;
   logic              evict_ready;
   logic [IDX_W-1:0]  evict_idx;
   logic [TAG_W-1:0]  evict_tag;
   logic [DATA_W-1:0] evict_data;

   modport slave (
      input  ld_rd_en, ld_rd_idx, ld_rd_tag,
      output ld_rd_data, ld_rd_hit,
      input  st_wr_en, st_wr_idx, st_wr_tag, st_wr_data,
      output st_wr_done,
      input  fill_en, fill_idx, fill_tag, fill_data,
      output fill_ready,
      output evict_valid, evict_idx, evict_tag, evict_data,
      input  evict_ready
   );

   modport master (
      output ld_rd_en, ld_rd_idx, ld_rd_tag,
      input  ld_rd_data, ld_rd_hit,
      output st_wr_en, st_wr_idx, st_wr_tag, st_wr_data,
      input  st_wr_done,
      output fill_en, fill_idx, fill_tag, fill_data,
      input  fill_ready,
      input  evict_valid, evict_idx, evict_tag, evict_data,
      output evict_ready
   );

endinterface

// File: rtl/dcache_assoc_mem_lru.sv
// ---------------------------------------------------------------------------
// dcache_lru : per-set true-LRU state using one age counter per way.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   i_touch_en[2:0]   : touch strobes, applied in order 0 (load), 1 (store),
//                       2 (fill); the highest-numbered touch ends up MRU
//   i_touch_idx/way   : set and way of each touch
//   i_victim_idx      : set being filled
//   i_victim_valid    : valid bits of that set
//   o_victim_way      : lowest invalid way, else the oldest (max-age) way
// Within a set the ages are always a permutation of 0..WAYS-1.
// ---------------------------------------------------------------------------
module dcache_lru
   import dcache_pkg::*;
#(
   parameter int SETS  = DCACHE_SETS,
   parameter int WAYS  = DCACHE_WAYS,
   parameter int IDX_W = $clog2(SETS),
   parameter int WAY_W = age_w(WAYS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [2:0]            i_touch_en,
   input  logic [2:0][IDX_W-1:0] i_touch_idx,
   input  logic [2:0][WAY_W-1:0] i_touch_way,
   input  logic [IDX_W-1:0]      i_victim_idx,
   input  logic [WAYS-1:0]       i_victim_valid,
   output logic [WAY_W-1:0]      o_victim_way
);

   logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] r_age;
   logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] w_age_nxt;
   logic [WAY_W-1:0]                     w_old;
   logic [WAY_W-1:0]                     w_inv_way;
   logic                                 w_inv_found;
   logic [WAY_W-1:0]                     w_old_way;

   // Touches are chained so same-set touches in one cycle compose in order.
   always_comb begin
      w_age_nxt = r_age;
      w_old     = '0;
      for (int t = 0; t < 3; t++) begin
         if (i_touch_en[t]) begin
            w_old = w_age_nxt[i_touch_idx[t]][i_touch_way[t]];
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == i_touch_way[t])
                  w_age_nxt[i_touch_idx[t]][w] = '0;
               else if (w_age_nxt[i_touch_idx[t]][w] < w_old)
                  w_age_nxt[i_touch_idx[t]][w] = w_age_nxt[i_touch_idx[t]][w] + WAY_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               r_age[s][w] <= WAY_W'(w);
      end else begin
         r_age <= w_age_nxt;
      end
   end

   // Victim: invalid ways first (lowest index wins), otherwise the way whose
   // age is WAYS-1, which is unique because ages form a permutation.
   always_comb begin
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      w_old_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!i_victim_valid[w]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(w);
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (r_age[i_victim_idx][w] == WAY_W'(WAYS - 1))
            w_old_way = WAY_W'(w);
      end
      o_victim_way = w_inv_found ? w_inv_way : w_old_way;
   end

endmodule

// File: rtl/dcache_assoc_mem.sv
// ---------------------------------------------------------------------------
// dcache_assoc_mem : N-way set-associative L1 data array with true-LRU
// replacement, per-line dirty bits and a one-entry eviction buffer.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : load lookup (combinational), store write-hit,
//                  line fill (gated by fill_ready = !evict_valid) and
//                  dirty-victim drain over a valid/ready handshake.
// Loads see pre-edge contents; stores and fills commit at the next edge.
// ---------------------------------------------------------------------------
module dcache_assoc_mem
   import dcache_pkg::*;
#(
   parameter int SETS   = DCACHE_SETS,
   parameter int WAYS   = DCACHE_WAYS,
   parameter int TAG_W  = DCACHE_TAG_W,
   parameter int DATA_W = DCACHE_DATA_W,
   parameter int IDX_W  = $clog2(SETS)
) (
   input  logic                clock,
   input  logic                reset,
   dcache_assoc_mem_if.slave   bus
);

   localparam int WAY_W = age_w(WAYS);

   // Same layout as dc_line_t / dc_evict_t, sized by this instance.
   typedef struct packed {
      logic              valid;
      logic              dirty;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } line_t;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } evict_t;

   line_t  r_line [SETS][WAYS];
   evict_t r_evict;
   logic   r_evict_valid;

   logic                  w_ld_hit, w_st_hit, w_fl_hit;
   logic [WAY_W-1:0]      w_ld_way, w_st_way, w_fl_hit_way;
   logic [WAY_W-1:0]      w_victim_way, w_fill_way;
   logic [WAYS-1:0]       w_fill_valid;
   logic                  w_fill_acc, w_st_done, w_evict_load;
   line_t                 w_victim_line;
   logic [2:0]            w_touch_en;
   logic [2:0][IDX_W-1:0] w_touch_idx;
   logic [2:0][WAY_W-1:0] w_touch_way;

   // Tag match in the three addressed sets. Fills that hit overwrite in
   // place, so at most one way can ever match.
   always_comb begin
      w_ld_hit     = 1'b0;
      w_ld_way     = '0;
      w_st_hit     = 1'b0;
      w_st_way     = '0;
      w_fl_hit     = 1'b0;
      w_fl_hit_way = '0;
      w_fill_valid = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_line[bus.ld_rd_idx][w].valid && r_line[bus.ld_rd_idx][w].tag == bus.ld_rd_tag) begin
            w_ld_hit = 1'b1;
            w_ld_way = WAY_W'(w);
         end
         if (r_line[bus.st_wr_idx][w].valid && r_line[bus.st_wr_idx][w].tag == bus.st_wr_tag) begin
            w_st_hit = 1'b1;
            w_st_way = WAY_W'(w);
         end
         if (r_line[bus.fill_idx][w].valid && r_line[bus.fill_idx][w].tag == bus.fill_tag) begin
            w_fl_hit     = 1'b1;
            w_fl_hit_way = WAY_W'(w);
         end
         w_fill_valid[w] = r_line[bus.fill_idx][w].valid;
      end
   end

   assign w_fill_acc    = bus.fill_en && !r_evict_valid;
   assign w_fill_way    = w_fl_hit ? w_fl_hit_way : w_victim_way;
   assign w_victim_line = r_line[bus.fill_idx][w_fill_way];
   // A fill that replaces the very way a store hits wins; the store retries.
   assign w_st_done     = bus.st_wr_en && w_st_hit &&
                          !(w_fill_acc && bus.fill_idx == bus.st_wr_idx && w_fill_way == w_st_way);
   assign w_evict_load  = w_fill_acc && !w_fl_hit && w_victim_line.valid && w_victim_line.dirty;

   assign bus.ld_rd_hit   = w_ld_hit;
   assign bus.ld_rd_data  = w_ld_hit ? r_line[bus.ld_rd_idx][w_ld_way].data : '0;
   assign bus.st_wr_done  = w_st_done;
   assign bus.fill_ready  = !r_evict_valid;
   assign bus.evict_valid = r_evict_valid;
   assign bus.evict_idx   = r_evict.idx;
   assign bus.evict_tag   = r_evict.tag;
   assign bus.evict_data  = r_evict.data;

   // Touch order 0=load, 1=store, 2=fill: the fill becomes MRU on ties.
   assign w_touch_en  = {w_fill_acc, w_st_done, bus.ld_rd_en && w_ld_hit};
   assign w_touch_idx = {bus.fill_idx, bus.st_wr_idx, bus.ld_rd_idx};
   assign w_touch_way = {w_fill_way, w_st_way, w_ld_way};

   dcache_lru #(
      .SETS  (SETS),
      .WAYS  (WAYS),
      .IDX_W (IDX_W),
      .WAY_W (WAY_W)
   ) u_lru (
      .clock          (clock),
      .reset          (reset),
      .i_touch_en     (w_touch_en),
      .i_touch_idx    (w_touch_idx),
      .i_touch_way    (w_touch_way),
      .i_victim_idx   (bus.fill_idx),
      .i_victim_valid (w_fill_valid),
      .o_victim_way   (w_victim_way)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               r_line[s][w] <= '0;
         r_evict       <= '0;
         r_evict_valid <= 1'b0;
      end else begin
         if (w_st_done) begin
            r_line[bus.st_wr_idx][w_st_way].data  <= bus.st_wr_data;
            r_line[bus.st_wr_idx][w_st_way].dirty <= 1'b1;
         end
         if (w_fill_acc)
            r_line[bus.fill_idx][w_fill_way] <= '{1'b1, 1'b0, bus.fill_tag, bus.fill_data};
         // Victim is captured from pre-edge contents; a fill is only accepted
         // with the buffer empty, so load and drain never coincide.
         if (w_evict_load) begin
            r_evict       <= '{bus.fill_idx, w_victim_line.tag, w_victim_line.data};
            r_evict_valid <= 1'b1;
         end else if (r_evict_valid && bus.evict_ready) begin
            r_evict_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/dcache_assoc_mem.md
Name: dcache_assoc_mem

Overview:
- Parametrised N-way set-associative data array for the L1 data cache; successor to the direct-mapped 32x64 array.
- Adds per-set true-LRU replacement, per-line dirty bits and a one-entry eviction buffer with a valid/ready handshake toward the memory-side writeback path.
- Sits between the LSQ (load read, store write-hit) and the dcache controller (fill, eviction drain).

Parameters:
- SETS, 32, number of sets; power of 2.
- WAYS, 2, associativity; power of 2, 1..8.
- TAG_W, 8, tag width.
- DATA_W, 64, line data width.
- IDX_W, $clog2(SETS), derived index width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ld_rd_en  in  1  load lookup; touches LRU on hit.
- ld_rd_idx  in  IDX_W  load set index.
- ld_rd_tag  in  TAG_W  load tag.
- ld_rd_data  out  DATA_W  hit-way data; 0 on miss; combinational.
- ld_rd_hit  out  1  valid way with matching tag exists; combinational.
- st_wr_en  in  1  store write request.
- st_wr_idx  in  IDX_W  store set index.
- st_wr_tag  in  TAG_W  store tag.
- st_wr_data  in  DATA_W  store data.
- st_wr_done  out  1  store is committed this cycle (hit and no conflict); combinational.
- fill_en  in  1  line fill from memory; sampled only when fill_ready is high.
- fill_idx  in  IDX_W  fill set index.
- fill_tag  in  TAG_W  fill tag.
- fill_data  in  DATA_W  fill data.
- fill_ready  out  1  equals !evict_valid.
- evict_valid  out  1  eviction buffer holds a dirty victim.
- evict_ready  in  1  writeback path accepts the victim.
- evict_idx  out  IDX_W  victim set index.
- evict_tag  out  TAG_W  victim tag.
- evict_data  out  DATA_W  victim data.

Behaviour:
- Reset, synchronous: all valid and dirty bits 0; data and tags 0; way w age = w, so way WAYS-1 is LRU; evict_valid/idx/tag/data all 0.
- Lookup is combinational on current state. Multiple matching ways cannot occur; the design guarantees this through fill-hit handling.
- LRU: per-set age counters, $clog2(WAYS) bits per way.
  - Touching way w sets age[w]=0 and increments every age that was below the old age[w].
  - Touches occur on a load hit with ld_rd_en, on st_wr_done, and on an accepted fill.
  - Same-set touches in one cycle apply in order: load, then store, then fill. The last touch becomes MRU.
- Store: st_wr_done = st_wr_en && hit && !(accepted fill targets the same set and way). On done, at the next edge: data <= st_wr_data, dirty <= 1. A store miss writes nothing; the LSQ retries after the fill.
- Fill, accepted when fill_en && fill_ready:
  - If the tag already hits in the set, overwrite that way. Dirty <= 0; no eviction.
  - Otherwise the victim is the lowest-numbered invalid way, else the max-age way. The way is written with valid=1, dirty=0, the new tag and data.
  - If the victim was valid and dirty, at the same edge the buffer loads its old idx/tag/data (pre-store) and evict_valid <= 1.
- fill_en while fill_ready is 0 is ignored, with no state change; the controller holds it.
- Eviction handshake: transfer at the edge where evict_valid && evict_ready, then evict_valid <= 0. Outputs are stable while valid && !ready. fill_ready rises the cycle after the drain; there is no same-cycle bypass.
- Load and fill to the same set in the same cycle: the load sees pre-fill contents.
- Reset mid-eviction: the buffer is cleared and the pending victim is dropped. This is by design; the controller also resets.
- Load latency is 0 cycles (combinational). Write and fill latency is 1 edge.

Decomposition:
- Shared package dcache_pkg holds the DCACHE_SETS/WAYS/TAG_W/DATA_W defaults, typedef dc_line_t {valid, dirty, tag, data}, and typedef dc_evict_t {idx, tag, data}.
- One sub-module, dcache_lru: per-set age array with two inputs, touch_en[3]/touch_idx/touch_way and victim_idx→victim_way, plus an invalid-way priority encoder.

Test Plan:
- Reset, then load idx 3 tag 0x12 → ld_rd_hit=0, ld_rd_data=0. evict_valid=0, fill_ready=1.
- Fill idx 3 tag 0x12 data 0xAA, then tag 0x34 data 0xBB → ways 0 and 1 are valid. Loads return 0xAA and 0xBB with hit=1. No eviction.
- Store hit idx 3 tag 0x12 data 0xCC, then load tag 0x34, then fill tag 0x56 data 0xDD → the victim is way 0 (tag 0x12, the LRU). Next cycle evict_valid=1, evict_tag=0x12, evict_data=0xCC, fill_ready=0.
- Hold evict_ready=0 for 3 cycles with fill_en=1 → evict outputs are stable and the fill is ignored. Set evict_ready=1 → evict_valid=0 next cycle, and fill_ready=1 on the cycle after the drain edge.
- Same cycle: store to idx 3 tag 0x34 while a fill replaces that way → st_wr_done=0 and the fill data lands. Store to the other way in the same set → st_wr_done=1 and both writes land.
- Refill of the resident tag 0x56 with data 0xEE → the same way is overwritten, dirty=0, no eviction. Assert reset while evict_valid=1 → evict_valid=0 and all lookups miss next cycle.
